// File: rtl/head_sram_rd_seq.sv
// head_sram_rd_seq: read-address sequencer for the head SRAM.
// Walks base + idx*stride (accumulated) over cfg_len words, cfg_repeat times,
// honours stall, and tags the final read so rdata_last/finish line up with
// the SRAM read latency.
//
// state | meaning
// IDLE  | waiting for start; first word is issued on the accepting edge
// RUN   | issuing words, one per non-stalled cycle
// DRAIN | all words issued; waiting for the last-tagged word to leave the pipe
// DONE  | one-cycle completion state (finish for non-empty jobs)
module head_sram_rd_seq #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int REP_W  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic              stall,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              rdata_vld,
  output logic              rdata_last,
  output logic              busy,
  output logic              finish
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, stride_q, stride_d, addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [REP_W-1:0]  rep_q, rep_d, pass_q, pass_d;
  logic              ren_q, ren_d, tag_q, tag_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              empty_q, empty_d, fin_empty_q;
  logic [RD_LAT-1:0] vld_sr_q, lst_sr_q;

  // Effective walk context: straight from cfg_* on the accepting cycle so the
  // first word goes out without a bubble, otherwise from the latched copy.
  logic              in_idle;
  logic [ADDR_W-1:0] c_base, c_stride, c_addr;
  logic [LEN_W-1:0]  c_len, c_idx;
  logic [REP_W-1:0]  c_rep, c_pass;
  logic              issue_ok, w_last, p_last;

  assign in_idle  = (state_q == S_IDLE);
  assign c_base   = in_idle ? cfg_base   : base_q;
  assign c_stride = in_idle ? cfg_stride : stride_q;
  assign c_addr   = in_idle ? cfg_base   : addr_q;
  assign c_len    = in_idle ? cfg_len    : len_q;
  assign c_idx    = in_idle ? '0         : idx_q;
  assign c_rep    = in_idle ? cfg_repeat : rep_q;
  assign c_pass   = in_idle ? '0         : pass_q;
  assign w_last   = (c_idx == c_len - LEN_W'(1));
  assign p_last   = (c_pass == c_rep - REP_W'(1));

  // Next-state, config capture and read-issue decision.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    stride_d = stride_q;
    len_d    = len_q;
    rep_d    = rep_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    addr_d   = addr_q;
    empty_d  = empty_q;
    ren_d    = 1'b0;
    tag_d    = 1'b0;
    raddr_d  = raddr_q;
    issue_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = cfg_base;
          stride_d = cfg_stride;
          len_d    = cfg_len;
          rep_d    = cfg_repeat;
          idx_d    = '0;
          pass_d   = '0;
          addr_d   = cfg_base;
          if (cfg_len == '0 || cfg_repeat == '0) begin
            state_d = S_DONE;
            empty_d = 1'b1;
          end else begin
            state_d  = S_RUN;
            empty_d  = 1'b0;
            issue_ok = 1'b1;
          end
        end
      end
      S_RUN:   issue_ok = 1'b1;
      S_DRAIN: if (rdata_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (issue_ok && !stall) begin
      ren_d   = 1'b1;
      raddr_d = c_addr;
      if (w_last && p_last) begin
        tag_d   = 1'b1;
        state_d = S_DRAIN;
      end else if (w_last) begin
        idx_d  = '0;
        pass_d = c_pass + REP_W'(1);
        addr_d = c_base;
      end else begin
        idx_d  = c_idx + LEN_W'(1);
        addr_d = c_addr + c_stride;
      end
    end
    if (abort) begin
      state_d = S_IDLE;
      ren_d   = 1'b0;
      tag_d   = 1'b0;
    end
  end

  // State, counters and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      addr_q      <= '0;
      empty_q     <= 1'b0;
      ren_q       <= 1'b0;
      tag_q       <= 1'b0;
      raddr_q     <= '0;
      fin_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      addr_q      <= addr_d;
      empty_q     <= empty_d;
      ren_q       <= ren_d;
      tag_q       <= tag_d;
      raddr_q     <= raddr_d;
      // An empty job spends its single busy cycle in DONE and reports finish
      // on the cycle after.
      fin_empty_q <= (state_q == S_DONE) && empty_q && !abort;
    end
  end

  // Read-latency pipe of {ren, last}; keeps shifting through stall, flushed on abort.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      vld_sr_q <= '0;
      lst_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= ren_q;
      lst_sr_q[0] <= ren_q & tag_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
        lst_sr_q[i] <= lst_sr_q[i-1];
      end
    end
  end

  assign ren        = ren_q;
  assign raddr      = raddr_q;
  assign rdata_vld  = vld_sr_q[RD_LAT-1];
  assign rdata_last = lst_sr_q[RD_LAT-1];
  assign busy       = !in_idle;
  assign finish     = ((state_q == S_DONE) && !empty_q) || fin_empty_q;

endmodule

// File: tb/tb_head_sram_rd_seq.sv
// Bench for head_sram_rd_seq: two instances (RD_LAT 1 and 3) share stimulus;
// each is compared every cycle against a job-level reference model.
module tb_head_sram_rd_seq;
  logic       clk = 1'b0;
  logic       rst, start, abort, stall;
  logic [9:0] cfg_base, cfg_stride;
  logic [10:0] cfg_len;
  logic [3:0] cfg_repeat;
  logic [1:0] ren, vld, lst, busy, fin;
  logic [9:0] raddr [2];

  always #5 clk = ~clk;

  head_sram_rd_seq #(.ADDR_W(10), .LEN_W(11), .REP_W(4), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_stride(cfg_stride), .cfg_repeat(cfg_repeat), .stall(stall),
    .ren(ren[0]), .raddr(raddr[0]), .rdata_vld(vld[0]), .rdata_last(lst[0]),
    .busy(busy[0]), .finish(fin[0]));

  head_sram_rd_seq #(.ADDR_W(10), .LEN_W(11), .REP_W(4), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_stride(cfg_stride), .cfg_repeat(cfg_repeat), .stall(stall),
    .ren(ren[1]), .raddr(raddr[1]), .rdata_vld(vld[1]), .rdata_last(lst[1]),
    .busy(busy[1]), .finish(fin[1]));

  int n_chk = 0;
  int n_fail = 0;
  int lat [2] = '{1, 3};

  // Reference model: expected outputs for the current cycle plus job bookkeeping.
  bit e_ren[2], e_vld[2], e_last[2], e_busy[2], e_fin[2], e_done[2], e_empty[2];
  int e_raddr[2];
  bit h_v[2][4], h_l[2][4];
  int lst_q[2][64];
  int hd[2], tl[2];
  int dut_iss[2], dut_fin[2];

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one cycle given this cycle's inputs.
  task automatic model_next(input int u, input bit s, input bit a, input bit st);
    bit acc, n_ren, n_tag, n_vld, n_last, n_fin, n_done, n_busy;
    int n_raddr;
    acc     = s && !a && !e_busy[u];
    n_ren   = 1'b0;
    n_tag   = 1'b0;
    n_raddr = e_raddr[u];
    n_vld   = h_v[u][lat[u]-1];
    n_last  = h_l[u][lat[u]-1];
    n_fin   = e_last[u] || (e_done[u] && e_empty[u]);
    n_done  = e_last[u];
    n_busy  = e_busy[u] && !e_done[u];
    if (acc) begin
      n_busy = 1'b1;
      hd[u]  = 0;
      tl[u]  = 0;
      if (cfg_len == 0 || cfg_repeat == 0) begin
        n_done     = 1'b1;
        e_empty[u] = 1'b1;
      end else begin
        e_empty[u] = 1'b0;
        for (int p = 0; p < int'(cfg_repeat); p++)
          for (int i = 0; i < int'(cfg_len); i++)
            if (tl[u] < 64) begin
              lst_q[u][tl[u]] = (int'(cfg_base) + i * int'(cfg_stride)) % 1024;
              tl[u]++;
            end
      end
    end
    if (hd[u] < tl[u] && !st) begin
      n_ren   = 1'b1;
      n_raddr = lst_q[u][hd[u]];
      hd[u]++;
      n_tag   = (hd[u] == tl[u]);
    end
    if (a) begin
      n_ren = 0; n_tag = 0; n_vld = 0; n_last = 0;
      n_fin = 0; n_done = 0; n_busy = 0;
      hd[u] = tl[u];
    end
    for (int k = 3; k > 0; k--) begin
      h_v[u][k] = a ? 1'b0 : h_v[u][k-1];
      h_l[u][k] = a ? 1'b0 : h_l[u][k-1];
    end
    h_v[u][0]  = n_ren;
    h_l[u][0]  = n_tag;
    e_ren[u]   = n_ren;
    e_raddr[u] = n_raddr;
    e_vld[u]   = n_vld;
    e_last[u]  = n_last;
    e_fin[u]   = n_fin;
    e_done[u]  = n_done;
    e_busy[u]  = n_busy;
  endtask

  // One clock: drive inputs, advance model, then compare after the edge.
  task automatic step(input bit s, input bit a, input bit st, input bit r);
    start = s; abort = a; stall = st; rst = r;
    for (int u = 0; u < 2; u++) model_next(u, s, a || r, st);
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check_val($sformatf("ren%0d", u), int'(ren[u]), int'(e_ren[u]));
      check_val($sformatf("vld%0d", u), int'(vld[u]), int'(e_vld[u]));
      check_val($sformatf("last%0d", u), int'(lst[u]), int'(e_last[u]));
      check_val($sformatf("busy%0d", u), int'(busy[u]), int'(e_busy[u]));
      check_val($sformatf("finish%0d", u), int'(fin[u]), int'(e_fin[u]));
      if (e_ren[u]) check_val($sformatf("raddr%0d", u), int'(raddr[u]), e_raddr[u]);
      dut_iss[u] += int'(ren[u]);
      dut_fin[u] += int'(fin[u]);
    end
  endtask

  task automatic set_cfg(input int b, input int l, input int sd, input int rp);
    cfg_base = 10'(b); cfg_len = 11'(l); cfg_stride = 10'(sd); cfg_repeat = 4'(rp);
  endtask

  int i0, f0, f1;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check_val("rst_ren", int'(ren[u]), 0);
      check_val("rst_raddr", int'(raddr[u]), 0);
      check_val("rst_vld", int'(vld[u]), 0);
      check_val("rst_last", int'(lst[u]), 0);
      check_val("rst_busy", int'(busy[u]), 0);
      check_val("rst_finish", int'(fin[u]), 0);
    end
    step(0, 0, 0, 0);

    // basic walk
    set_cfg('h010, 4, 1, 1);
    i0 = dut_iss[0]; f0 = dut_fin[0];
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    check_val("basic_issues", dut_iss[0] - i0, 4);
    check_val("basic_finish", dut_fin[0] - f0, 1);

    // stride, repeat and address wrap
    set_cfg('h3FE, 3, 2, 2);
    i0 = dut_iss[0];
    step(1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);
    check_val("wrap_issues", dut_iss[0] - i0, 6);

    // stall for two cycles after the second issue
    set_cfg('h020, 4, 1, 1);
    i0 = dut_iss[0];
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 0);
    check_val("stall_issues", dut_iss[0] - i0, 4);

    // zero length
    set_cfg('h055, 0, 1, 3);
    i0 = dut_iss[0]; f0 = dut_fin[0];
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    check_val("zero_issues", dut_iss[0] - i0, 0);
    check_val("zero_finish", dut_fin[0] - f0, 1);

    // abort mid-run, then a normal job
    set_cfg('h100, 8, 3, 1);
    f0 = dut_fin[0]; f1 = dut_fin[1];
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    check_val("abort_finish0", dut_fin[0] - f0, 0);
    check_val("abort_finish1", dut_fin[1] - f1, 0);
    set_cfg('h200, 2, 5, 1);
    f1 = dut_fin[1];
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    check_val("post_abort_finish", dut_fin[1] - f1, 1);

    // start together with abort in IDLE
    set_cfg('h010, 4, 1, 1);
    i0 = dut_iss[0];
    step(1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    check_val("start_abort_issues", dut_iss[0] - i0, 0);

    // start while busy is ignored, cfg changes mid-job have no effect
    i0 = dut_iss[0];
    step(1, 0, 0, 0);
    set_cfg('h300, 6, 7, 2);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    check_val("busy_start_issues", dut_iss[0] - i0, 4);

    // reset mid-job
    set_cfg('h040, 5, 1, 1);
    f0 = dut_fin[0];
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0);
    check_val("reset_mid_finish", dut_fin[0] - f0, 0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0)
        set_cfg(int'($urandom_range(0, 1023)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
      step($urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 249) == 0);
    end
    repeat (8) step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
